// File: rtl/pgm_mem_pkg.sv
// Shared types and default widths for the PGM SDRAM arbiter.
// Optional macro PGM_ARB_RR_EN selects round-robin cpu/snd arbitration.
package pgm_mem_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;

    // OWN_NONE is the cleared value; the one-hot ack outputs index from OWN_LD upward.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_SND  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pgm_arb_pick.sv
// Winner select for the PGM SDRAM arbiter plus its fairness state.
// Default: fixed priority ld > cpu > snd with a starvation counter that forces
// snd to win after STARVE_MAX cpu grants. With PGM_ARB_RR_EN defined, cpu and
// snd alternate on ties using a last-winner bit; ld always wins in both modes.
module pgm_arb_pick
    import pgm_mem_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic   clk,
    input  logic   srst,
    input  logic   in_idle,
    input  logic   mem_busy,
    input  logic   ioctl_download,
    input  logic   ld_req,
    input  logic   cpu_req,
    input  logic   snd_req,
    output logic   grant,
    output owner_t win_owner
);

    logic win_valid;
    logic snd_pref;
    logic cpu_ok;
    logic snd_ok;

    assign cpu_ok = cpu_req & ~ioctl_download;
    assign snd_ok = snd_req & ~ioctl_download;
    assign grant  = in_idle & ~mem_busy & win_valid;

`ifdef PGM_ARB_RR_EN
    // Set when cpu won the last contested-or-not grant; snd is preferred next.
    logic last_cpu_reg;
    logic last_cpu_next;

    assign snd_pref = last_cpu_reg;

    // Track the most recent cpu/snd winner.
    always_comb begin
        last_cpu_next = last_cpu_reg;
        if (grant && win_owner == OWN_CPU) begin
            last_cpu_next = 1'b1;
        end else if (grant && win_owner == OWN_SND) begin
            last_cpu_next = 1'b0;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_cpu_reg <= 1'b0;
        end else begin
            last_cpu_reg <= last_cpu_next;
        end
    end
`else
    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;

    assign snd_pref = (starve_cnt_reg == CNT_MAX);

    // Count cpu grants taken while snd waits; only meaningful in IDLE.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (in_idle) begin
            if (grant && win_owner == OWN_SND) begin
                starve_cnt_next = '0;
            end else if (!snd_req) begin
                starve_cnt_next = '0;
            end else if (grant && win_owner == OWN_CPU && starve_cnt_reg != CNT_MAX) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end
`endif

    // Priority select: loader first, then cpu/snd according to snd_pref on a tie.
    always_comb begin
        win_valid = 1'b0;
        win_owner = OWN_NONE;
        if (ld_req) begin
            win_valid = 1'b1;
            win_owner = OWN_LD;
        end else if (cpu_ok && snd_ok) begin
            win_valid = 1'b1;
            win_owner = snd_pref ? OWN_SND : OWN_CPU;
        end else if (cpu_ok) begin
            win_valid = 1'b1;
            win_owner = OWN_CPU;
        end else if (snd_ok) begin
            win_valid = 1'b1;
            win_owner = OWN_SND;
        end
    end

endmodule

// File: rtl/pgm_sdram_arb.sv
// Shares one SDRAM controller port between the ROM loader, the 68k and the
// sound engine. One transaction in flight; command fields are latched at grant
// and held until completion, read data is held per requester after its ack.
// Optional macro PGM_ARB_RR_EN (see pgm_arb_pick) selects round-robin cpu/snd.
module pgm_sdram_arb
    import pgm_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              snd_req,
    input  logic [ADDR_W-1:0] snd_addr,
    output logic [DATA_W-1:0] snd_rdata,
    output logic              snd_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    owner_t            owner_reg;
    owner_t            win_owner;
    logic              grant;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] snd_rdata_reg;
    logic [2:0]        ack_vec;

    pgm_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk            (clk_sys),
        .srst           (reset),
        .in_idle        (state_reg == IDLE),
        .mem_busy       (mem_busy),
        .ioctl_download (ioctl_download),
        .ld_req         (ld_req),
        .cpu_req        (cpu_req),
        .snd_req        (snd_req),
        .grant          (grant),
        .win_owner      (win_owner)
    );

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: grant -> one-cycle strobe -> wait for done -> one-cycle ack.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_done) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch command fields at grant and capture read data on completion.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            owner_reg     <= OWN_NONE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            cpu_rdata_reg <= '0;
            snd_rdata_reg <= '0;
        end else begin
            if (state_reg == IDLE && grant) begin
                owner_reg <= win_owner;
                case (win_owner)
                    OWN_LD: begin
                        addr_reg  <= ld_addr;
                        wdata_reg <= ld_wdata;
                        we_reg    <= 1'b1;
                    end
                    OWN_CPU: begin
                        addr_reg  <= cpu_addr;
                        wdata_reg <= '0;
                        we_reg    <= 1'b0;
                    end
                    OWN_SND: begin
                        addr_reg  <= snd_addr;
                        wdata_reg <= '0;
                        we_reg    <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state_reg == WAIT && mem_done) begin
                if (owner_reg == OWN_CPU) cpu_rdata_reg <= mem_rdata;
                if (owner_reg == OWN_SND) snd_rdata_reg <= mem_rdata;
            end
        end
    end

    // One ack line per owner, only the latched owner fires in ACK.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == ACK) && (owner_reg == owner_t'(gi + 1));
        end
    endgenerate

    assign ld_ack    = ack_vec[0];
    assign cpu_ack   = ack_vec[1];
    assign snd_ack   = ack_vec[2];
    assign mem_req   = (state_reg == ISSUE);
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign snd_rdata = snd_rdata_reg;

endmodule

// File: doc/pgm_sdram_arb.md
Name: pgm_sdram_arb

Overview:
- Arbitrates one shared SDRAM controller port between three requesters:
  - ROM loader (ioctl download writes)
  - 68k program/data reads
  - Z80/ICS sound-sample reads
- Sits between the PGM core and the single SDRAM controller instance.
- Serialises requests, allows one outstanding transaction, and routes read data and acknowledges back to the winning requester.

Parameters:
- ADDR_W, 25: SDRAM byte-address width (32 MB).
- DATA_W, 16: data width of every port.
- STARVE_MAX, 8: consecutive 68k grants that may be issued while audio is pending before audio is forced to win.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active; blocks 68k and audio grants.
- ld_req  in  1  loader write request; held until ld_ack.
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle pulse: write completed.
- cpu_req  in  1  68k read request; held until cpu_ack.
- cpu_addr  in  ADDR_W  68k byte address.
- cpu_rdata  out  DATA_W  68k read data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle pulse.
- snd_req  in  1  sound read request; held until snd_ack.
- snd_addr  in  ADDR_W  sound byte address.
- snd_rdata  out  DATA_W  sound read data; valid while snd_ack is high.
- snd_ack  out  1  one-cycle pulse.
- mem_req  out  1  one-cycle command strobe to the SDRAM controller.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_busy  in  1  controller cannot accept a command.
- mem_done  in  1  one-cycle pulse: transaction complete; mem_rdata valid.
- mem_rdata  in  DATA_W  controller read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0, owner cleared.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If mem_busy=0 and any eligible request is high, pick a winner, then latch its address, data, we and owner ID, and go to ISSUE.
  - Otherwise stay in IDLE.
- Eligibility and priority:
  - ld_req always wins.
  - While ioctl_download=1, cpu_req and snd_req are ineligible. They stay pending and get no ack.
  - Otherwise cpu wins over snd, unless starve_cnt==STARVE_MAX; then snd wins.
- ISSUE: mem_req=1 for exactly this cycle with the latched fields. Go to WAIT.
- WAIT:
  - Hold mem_addr, mem_wdata and mem_we stable.
  - On mem_done: capture mem_rdata into the owner's rdata register and go to ACK.
- ACK:
  - Exactly the owner's ack=1 for one cycle; rdata is held from then on. Go to IDLE.
  - Requesters drop req on the edge where they see ack. Because IDLE samples one cycle later, there is no double grant.
- Latency: request sampled in IDLE at cycle 0; mem_req at cycle 1; mem_done at cycle N; ack at cycle N+1. Minimum 3 cycles, 1 idle cycle between transactions.
- Starvation counter:
  - Increments on each cpu grant while snd_req=1.
  - Saturates at STARVE_MAX.
  - Clears on a snd grant, or whenever snd_req=0 in IDLE.
- Boundary rules:
  - Simultaneous ld, cpu and snd requests: ld wins first, then cpu, then snd (fixed mode, counter below max).
  - mem_done outside WAIT is ignored.
  - A request dropped before its ack is a protocol violation; the transaction still completes, but the ack still fires to the latched owner.
  - ioctl_download rising edge during a cpu transaction in flight: that transaction completes and acks normally; the block applies to new grants only.
  - reset in any state: return to IDLE at once, no ack, no mem_req. The controller is reset by the same signal.
  - mem_busy high in IDLE: no grant; requests keep waiting.

Optional Feature:
- PGM_ARB_RR_EN defined: cpu and snd use strict round-robin. A last-winner bit prefers the other requester on ties. The starvation counter and STARVE_MAX are unused, and ld keeps absolute priority.
- PGM_ARB_RR_EN undefined: fixed priority with the starvation guard as above.

Decomposition:
- Package pgm_mem_pkg holds:
  - owner enum: OWN_LD, OWN_CPU, OWN_SND
  - state enum: IDLE, ISSUE, WAIT, ACK
  - default ADDR_W and DATA_W constants
- One natural sub-module, pgm_arb_pick: the combinational winner select plus the starvation/round-robin register. It is pure logic apart from that one counter/bit.

Test Plan:
- Single cpu read: cpu_req at addr 0x000100, mem_done after 4 cycles with rdata 0xBEEF -> one mem_req with we=0, cpu_ack on cycle 6 with cpu_rdata=0xBEEF, no snd_ack or ld_ack.
- Download blocking: ioctl_download=1, ld_req writes 0x1234 to 0x0 while cpu_req is high -> only writes are issued, no cpu_ack; drop ioctl_download -> cpu read issued next.
- Starvation guard: cpu_req and snd_req both held continuously, STARVE_MAX=8 -> grant order 8×cpu, 1×snd, repeating. With PGM_ARB_RR_EN the order is strictly cpu, snd, cpu, snd.
- mem_busy stall: mem_busy=1 for 10 cycles with cpu_req high -> no mem_req until the cycle after busy falls.
- Reset mid-WAIT: reset asserted for 1 cycle in WAIT -> no ack, all outputs 0 next cycle, and a fresh request is served normally afterwards.
- Stray mem_done in IDLE: inject a mem_done pulse -> no ack and no state change.
